// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: fetch FSM state encodings, perf counter width and a saturating add helper.
package fetch_unit_pkg;
  typedef enum logic [1:0] {
    FETCH_ST_FETCH = 2'd0,
    FETCH_ST_DRAIN = 2'd1,
    FETCH_ST_HALT  = 2'd2
  } fetch_state_e;
  localparam int FETCH_PERF_W = 16;
  function automatic logic [FETCH_PERF_W-1:0] sat_inc(input logic [FETCH_PERF_W-1:0] c,
                                                      input logic [FETCH_PERF_W-1:0] n);
    logic [FETCH_PERF_W:0] s;
    s = {1'b0, c} + {1'b0, n};
    return s[FETCH_PERF_W] ? '1 : s[FETCH_PERF_W-1:0];
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush and a registered head that holds its last value when empty.
module fetch_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          flush,
  output logic [AW:0]   count,
  output logic          valid,
  output logic [W-1:0]  head
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr, rd_n;
  logic [AW:0] count_n;
  logic do_push, do_pop;
  assign valid = count != '0;
  assign do_pop = pop & valid & ~flush;
  assign do_push = push & ~flush;
  assign rd_n = rd + AW'(do_pop);
  assign count_n = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  // The new head is the incoming word whenever the queue is (or is becoming) empty.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      head <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      rd <= rd_n;
      wr <= wr + AW'(do_push);
      count <= count_n;
      if (count_n != '0) head <= (count == '0 || (count == (AW+1)'(1) && do_pop)) ? din : mem[rd_n];
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: prefetching instruction fetch with a DEPTH-entry queue, redirect/drain and halt.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_wait,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [FETCH_PERF_W-1:0] perf_fetched,
  output logic [FETCH_PERF_W-1:0] perf_flushed,
  output logic [FETCH_PERF_W-1:0] perf_wait
`endif
);
  localparam int BYTES = DATA_W / 8;
  localparam int SH = $clog2(BYTES);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_e state, state_n;
  logic [ADDR_W-1:0] fetch_pc, addr_q, target;
  logic [CW-1:0] cnt;
  logic pend, complete, push, issue;
  assign mem_req = pend;
  assign mem_addr = addr_q;
  assign complete = pend & ~mem_wait;
  assign push = complete & (state == FETCH_ST_FETCH) & ~redirect;
  assign issue = (state == FETCH_ST_FETCH) & ~pend & en & (cnt < CW'(DEPTH)) & ~redirect;
  assign target = redirect_pc & ~ADDR_W'(BYTES - 1);
  always_comb begin
    state_n = state;
    state_n = state == FETCH_ST_DRAIN ? (complete ? FETCH_ST_FETCH : FETCH_ST_DRAIN)
            : state == FETCH_ST_HALT ? (en ? FETCH_ST_FETCH : FETCH_ST_HALT)
            : (redirect & pend & ~complete) ? FETCH_ST_DRAIN
            : (~en & ~pend) ? FETCH_ST_HALT : FETCH_ST_FETCH;
  end
  // A request in flight keeps its address even when a redirect moves fetch_pc.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH_ST_FETCH;
      fetch_pc <= RESET_PC;
      pend <= 1'b0;
      addr_q <= '0;
    end else begin
      state <= state_n;
      fetch_pc <= redirect ? target : push ? fetch_pc + ADDR_W'(BYTES) : fetch_pc;
      pend <= pend ? mem_wait : issue;
      if (issue) addr_q <= fetch_pc >> SH;
    end
  fetch_fifo #(.W(DATA_W + ADDR_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din({mem_rdata, fetch_pc}),
    .pop(instr_ready),
    .flush(redirect),
    .count(cnt),
    .valid(instr_valid),
    .head({instr, instr_pc})
  );
`ifdef FETCH_PERF_EN
  logic [CW-1:0] flush_n;
  // Flushed words: entries cleared (minus a same-cycle pop the consumer took) plus any discarded completion.
  assign flush_n = (redirect ? cnt - CW'(instr_ready & instr_valid) : '0) + CW'(complete & ~push);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
      perf_wait <= '0;
    end else begin
      perf_fetched <= sat_inc(perf_fetched, FETCH_PERF_W'(push));
      perf_flushed <= sat_inc(perf_flushed, FETCH_PERF_W'(flush_n));
      perf_wait <= sat_inc(perf_wait, FETCH_PERF_W'(pend & mem_wait));
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus checked against a transaction-level fetch stream model.
module tb_fetch_unit;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, mem_wait = 1'b0, instr_ready = 1'b0, redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0, mem_addr, instr_pc;
  logic [DATA_W-1:0] mem_rdata = '0, instr;
  logic mem_req, instr_valid;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched, perf_flushed, perf_wait;
`endif
  int checks = 0, errors = 0;
  int occ, comps, pops, m_fetched, m_flushed, m_wait;
  logic drain, prev_pend, prev_en;
  logic [ADDR_W-1:0] want_pc, exp_pc, prev_a;
  logic [ADDR_W-1:0] popped[$];
  always #5 clk = ~clk;
  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wait(mem_wait), .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed), .perf_wait(perf_wait)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] pick(int i);
    return popped.size() > i ? 32'(popped[i]) : 32'hDEAD_BEEF;
  endfunction
  task automatic model_reset();
    occ = 0; drain = 0; prev_pend = 0; prev_en = 0;
    want_pc = '0; exp_pc = '0;
    m_fetched = 0; m_flushed = 0; m_wait = 0;
  endtask
  // One clock: memory answers with its word address, the stream model predicts what must be seen.
  task automatic cyc();
    logic r, v, comp, pop;
    logic [ADDR_W-1:0] a, p;
    logic [DATA_W-1:0] d;
    mem_rdata = DATA_W'(mem_addr);
    @(negedge clk);
    r = mem_req; a = mem_addr; v = instr_valid; p = instr_pc; d = instr;
    if (prev_pend) begin
      chk("hold_req", r, 1);
      chk("hold_addr", a, prev_a);
    end else if (r) begin
      chk("req_addr", a, want_pc >> 1);
      chk("req_after_en", prev_en, 1);
    end
    chk("valid", v, occ != 0);
    if (v) begin
      chk("head_pc", p, exp_pc);
      chk("head_data", d, DATA_W'(exp_pc >> 1));
    end
    comp = r && !mem_wait;
    pop = v && instr_ready;
    if (r && mem_wait) m_wait++;
    if (comp) comps++;
    if (pop) begin pops++; popped.push_back(p); end
    if (redirect) begin
      m_flushed += occ - int'(pop) + int'(comp);
      drain = r && !comp;
      occ = 0;
      exp_pc = redirect_pc & ~16'h1;
      want_pc = exp_pc;
    end else begin
      if (comp && drain) begin
        drain = 0;
        m_flushed++;
      end else if (comp) begin
        chk("room", occ < DEPTH, 1);
        occ++; want_pc += 2; m_fetched++;
      end
      if (pop) begin occ--; exp_pc += 2; end
    end
    prev_pend = r && mem_wait;
    prev_a = a;
    prev_en = en;
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic wait_req();
    int n = 0;
    while (!mem_req && n < 20) begin cyc(); n++; end
  endtask
  task automatic wait_pops(int k);
    int n = 0;
    while (popped.size() < k && n < 40) begin cyc(); n++; end
  endtask
  initial begin
    logic found;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    do_reset();
    // streaming throughput
    en = 1; mem_wait = 0; instr_ready = 1; comps = 0; popped.delete();
    repeat (20) cyc();
    chk("throughput", comps, 10);
    chk("first_pc", pick(0), 16'h0000);
    chk("second_pc", pick(1), 16'h0002);
    // back-pressure fills exactly DEPTH entries
    do_reset();
    instr_ready = 0; comps = 0;
    repeat (20) cyc();
    chk("fill_comps", comps, DEPTH);
    chk("full_no_req", mem_req, 0);
    chk("full_head", instr_pc, 16'h0000);
    instr_ready = 1; cyc(); instr_ready = 0; comps = 0;
    repeat (10) cyc();
    chk("one_pop_one_req", comps, 1);
    // redirect while word 5 waits: drain it
    do_reset();
    instr_ready = 1; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_req && mem_addr == 16'd5) found = 1; else cyc();
    end
    chk("find_word5", found, 1);
    mem_wait = 1; redirect = 1; redirect_pc = 16'h0041;
    cyc();
    redirect = 0; popped.delete();
    cyc(); cyc();
    chk("drain_req", mem_req, 1);
    chk("drain_addr", mem_addr, 16'd5);
    mem_wait = 0;
    cyc();
    wait_req();
    chk("post_drain_addr", mem_addr, 16'h0020);
    wait_pops(1);
    chk("post_drain_pc", pick(0), 16'h0040);
    // redirect coinciding with a completion and a pop
    instr_ready = 0;
    repeat (6) cyc();
    instr_ready = 1; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_req && instr_valid) found = 1; else cyc();
    end
    chk("find_overlap", found, 1);
    redirect = 1; redirect_pc = 16'h0100;
    cyc();
    redirect = 0; popped.delete();
    chk("flush_valid", instr_valid, 0);
    wait_req();
    chk("overlap_addr", mem_addr, 16'h0080);
    wait_pops(1);
    chk("overlap_pc", pick(0), 16'h0100);
    // address wrap
    redirect = 1; redirect_pc = 16'hFFFC;
    cyc();
    redirect = 0; popped.delete();
    wait_pops(3);
    chk("wrap0", pick(0), 16'hFFFC);
    chk("wrap1", pick(1), 16'hFFFE);
    chk("wrap2", pick(2), 16'h0000);
    // asynchronous reset in the middle of a waited transfer
    instr_ready = 0;
    repeat (3) cyc();
    mem_wait = 1;
    wait_req();
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", mem_req, 0);
    chk("async_rst_valid", instr_valid, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; mem_wait = 0;
    wait_req();
    chk("restart_addr", mem_addr, 16'h0000);
    // random traffic against the stream model
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      en = $urandom_range(0, 9) != 0;
      mem_wait = $urandom_range(0, 2) == 0;
      instr_ready = $urandom_range(0, 3) != 0;
      redirect = $urandom_range(0, 39) == 0;
      redirect_pc = ADDR_W'($urandom);
      cyc();
    end
    chk("liveness", pops > 200, 1);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_flushed", perf_flushed, m_flushed);
    chk("perf_wait", perf_wait, m_wait);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
